id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Parametrised successor to the combinational decode stage: decodes RV32I integer, branch, jump, load and store instructions, with configurable operand forwarding.
- Adds a registered ID/EX pipeline register with valid/ready handshaking, load-use interlock and bubble insertion.
- Adds a redirect state machine that squashes a configurable number of wrong-path fetches after a taken branch or jump.
- Sits between IF and EX; also drives the register file read addresses.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediates.
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest and has highest priority.
- SHADOW, 1, number of accepted fetches discarded after a redirect (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (rst==0 resets).
- if_valid_i  in  1  IF presents an instruction.
- pc_i  in  XLEN  address of inst_i.
- inst_i  in  32  instruction word.
- id_ready_o  out  1  ID accepts inst_i this cycle.
- rs1_addr_o  out  5  regfile read address 1 (inst_i[19:15]).
- rs2_addr_o  out  5  regfile read address 2 (inst_i[24:20]).
- rs1_data_i  in  XLEN  regfile data 1.
- rs2_data_i  in  XLEN  regfile data 2.
- fwd_wen_i  in  NUM_FWD  forwarding source writes a register.
- fwd_addr_i  in  5*NUM_FWD  packed destination addresses.
- fwd_data_i  in  XLEN*NUM_FWD  packed result data.
- ex_is_load_i  in  1  instruction now in EX is a load.
- ex_rd_i  in  5  destination of the instruction in EX.
- ex_ready_i  in  1  EX can take a new ID/EX entry.
- ex_valid_o  out  1  ID/EX holds a valid instruction.
- ex_aluop_o  out  6  ALU/memory op code; 0 = NOP.
- ex_op1_o  out  XLEN  operand 1.
- ex_op2_o  out  XLEN  operand 2.
- ex_imm_o  out  XLEN  sign-extended immediate (store offset, load offset).
- ex_rd_o  out  5  destination register.
- ex_wreg_o  out  1  write-back enable.
- ex_link_o  out  XLEN  pc+4 for JAL/JALR.
- ex_illegal_o  out  1  registered illegal-instruction flag.
- jump_o  out  1  registered one-cycle redirect pulse.
- jump_addr_o  out  XLEN  redirect target, valid while jump_o=1.

Behaviour:
- Reset (rst=0, async): all registered outputs 0, jump_addr_o=0, FSM=RUN, kill counter 0.
- Decode and operand select are combinational. ID/EX register, jump_o/jump_addr_o and FSM update on the clk rising edge.
- Operand source, per rs:
  - address 0 always yields 0;
  - else the lowest-index fwd source with wen=1 and matching address;
  - else regfile data.
  - Operands not read by the instruction are replaced by the immediate (I-type op2).
- Load-use hazard when all hold: ex_is_load_i=1, ex_rd_i!=0, ex_rd_i equals a register the instruction actually reads, if_valid_i=1.
  - id_ready_o = ex_ready_i & ~hazard.
- Capture when ex_ready_i=1:
  - ID/EX loads the decoded instruction with ex_valid_o=1 if if_valid_i & ~hazard & FSM==RUN;
  - otherwise ID/EX loads a bubble (ex_valid_o=0, wreg=0, aluop=0).
  - ex_ready_i=0: ID/EX holds every field and id_ready_o=0.
- Latency: one cycle from acceptance to ex_valid_o.
- Immediates are sign-extended to XLEN from inst[31]. SLTIU compares against the sign-extended immediate as unsigned. Shift amounts use inst[24:20] zero-extended.
- Branch resolution in ID uses the forwarded operands: BEQ, BNE, signed BLT/BGE via $signed compare, unsigned BLTU/BGEU.
- Branch/jump targets:
  - branch taken or JAL: target = pc_i + imm;
  - JALR: target = (op1 + imm) & ~1;
  - addition wraps modulo 2^XLEN.
- On acceptance of a taken branch or jump: next cycle jump_o=1 with jump_addr_o=target; FSM goes RUN to KILL with counter=SHADOW.
- KILL state:
  - id_ready_o = ex_ready_i;
  - each accepted fetch is dropped as a bubble and decrements the counter;
  - cycles with if_valid_i=0 do not count;
  - at counter 0, return to RUN.
  - Branches in the shadow never redirect.
- Illegal opcode, funct3 or funct7: entered with ex_valid_o=1, wreg=0, aluop=0, ex_illegal_o=1. No redirect.
- Stores: wreg=0; op1=rs1, op2=rs2 data; ex_imm_o = S-immediate.
- Branches: wreg=0.
- rd=0 forces wreg=0.
- Reset asserted mid-KILL or mid-stall returns to RUN with an empty ID/EX register on release.

Test Plan:
- Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 with fwd0 = {wen=1, addr=1, data=5} -> second ID/EX entry has op1=op2=5, aluop=Add, rd=2.
- LW x3 in EX (ex_is_load_i=1, ex_rd_i=3) while ID holds ADD x4,x3,x0 -> id_ready_o=0, exactly one bubble, ADD enters next cycle with the MEM-forwarded value.
- BEQ at pc 0x100, imm=+0x20, equal operands, SHADOW=2 -> jump_o pulse with jump_addr_o=0x120; next two accepted fetches dropped, including a BNE in the shadow that produces no jump.
- JALR x1, 0(x5) with x5=0x203 -> jump_addr_o=0x202, ex_link_o=pc+4, wreg=1, rd=1.
- ex_ready_i held low 3 cycles with a valid ADD in ID/EX -> all ID/EX fields stable, id_ready_o=0.
- Opcode 0x7F presented, then rst=0 asserted mid-KILL -> ex_illegal_o=1 one cycle; after reset all outputs 0 and FSM=RUN.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with operand forwarding, a registered ID/EX entry,
// load-use interlock and a redirect FSM that squashes wrong-path fetches.
module id_stage_pipe #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int SHADOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_valid_i,
   input  logic [XLEN-1:0]         pc_i,
   input  logic [31:0]             inst_i,
   output logic                    id_ready_o,
   output logic [4:0]              rs1_addr_o,
   output logic [4:0]              rs2_addr_o,
   input  logic [XLEN-1:0]         rs1_data_i,
   input  logic [XLEN-1:0]         rs2_data_i,
   input  logic [NUM_FWD-1:0]      fwd_wen_i,
   input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
   input  logic                    ex_is_load_i,
   input  logic [4:0]              ex_rd_i,
   input  logic                    ex_ready_i,
   output logic                    ex_valid_o,
   output logic [5:0]              ex_aluop_o,
   output logic [XLEN-1:0]         ex_op1_o,
   output logic [XLEN-1:0]         ex_op2_o,
   output logic [XLEN-1:0]         ex_imm_o,
   output logic [4:0]              ex_rd_o,
   output logic                    ex_wreg_o,
   output logic [XLEN-1:0]         ex_link_o,
   output logic                    ex_illegal_o,
   output logic                    jump_o,
   output logic [XLEN-1:0]         jump_addr_o
);
   localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67,
                          OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                          OPC_OPIMM = 7'h13, OPC_OP = 7'h33;
   localparam logic [5:0] ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_SLL = 6'd3, ALU_SLT = 6'd4,
                          ALU_SLTU = 6'd5, ALU_XOR = 6'd6, ALU_SRL = 6'd7, ALU_SRA = 6'd8,
                          ALU_OR = 6'd9, ALU_AND = 6'd10, ALU_JAL = 6'h28, ALU_JALR = 6'h29;

   typedef enum logic {RUN, KILL} state_t;

   function automatic logic [5:0] alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
         3'd1:    alu_of = ALU_SLL;
         3'd2:    alu_of = ALU_SLT;
         3'd3:    alu_of = ALU_SLTU;
         3'd4:    alu_of = ALU_XOR;
         3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_of = ALU_OR;
         default: alu_of = ALU_AND;
      endcase
   endfunction

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt, pc4;

   assign opcode = inst_i[6:0];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];
   assign rd     = inst_i[11:7];
   assign rs1_addr_o = rs1;
   assign rs2_addr_o = rs2;

   assign imm_i = XLEN'($signed(inst_i[31:20]));
   assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
   assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
   assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
   assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
   assign shamt = XLEN'(inst_i[24:20]);
   assign pc4   = pc_i + XLEN'(4);

   logic [4:0]      fwd_addr [NUM_FWD];
   logic [XLEN-1:0] fwd_data [NUM_FWD];

   generate
      for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
         assign fwd_addr[gi] = fwd_addr_i[gi*5 +: 5];
         assign fwd_data[gi] = fwd_data_i[gi*XLEN +: XLEN];
      end
   endgenerate

   logic [XLEN-1:0] rs1_val, rs2_val;

   // Scan oldest to youngest so the lowest-index matching source wins.
   always_comb begin
      rs1_val = rs1_data_i;
      rs2_val = rs2_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_wen_i[k] && fwd_addr[k] == rs1) rs1_val = fwd_data[k];
         if (fwd_wen_i[k] && fwd_addr[k] == rs2) rs2_val = fwd_data[k];
      end
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end

   logic [5:0]      dec_aluop;
   logic [XLEN-1:0] dec_op1, dec_op2, dec_imm, dec_link, target;
   logic            dec_wreg, dec_illegal, uses_rs1, uses_rs2, take, br_cond;

   always_comb begin
      case (f3)
         3'd0:    br_cond = (rs1_val == rs2_val);
         3'd1:    br_cond = (rs1_val != rs2_val);
         3'd4:    br_cond = ($signed(rs1_val) < $signed(rs2_val));
         3'd5:    br_cond = ($signed(rs1_val) >= $signed(rs2_val));
         3'd6:    br_cond = (rs1_val < rs2_val);
         default: br_cond = (rs1_val >= rs2_val);
      endcase
   end

   always_comb begin
      dec_aluop = '0; dec_op1 = '0; dec_op2 = '0; dec_imm = '0; dec_link = '0; target = '0;
      dec_wreg = 1'b0; dec_illegal = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0; take = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            dec_op1 = (opcode == OPC_AUIPC) ? pc_i : '0;
            dec_op2 = imm_u; dec_imm = imm_u; dec_aluop = ALU_ADD; dec_wreg = 1'b1;
         end
         OPC_JAL: begin
            dec_op1 = pc_i; dec_op2 = imm_j; dec_imm = imm_j; dec_aluop = ALU_JAL;
            dec_wreg = 1'b1; dec_link = pc4; take = 1'b1; target = pc_i + imm_j;
         end
         OPC_JALR: begin
            dec_illegal = (f3 != 3'd0);
            uses_rs1 = 1'b1; dec_op1 = rs1_val; dec_op2 = imm_i; dec_imm = imm_i;
            dec_aluop = ALU_JALR; dec_wreg = 1'b1; dec_link = pc4; take = 1'b1;
            target = (rs1_val + imm_i) & ~XLEN'(1);
         end
         OPC_BRANCH: begin
            dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_op1 = rs1_val; dec_op2 = rs2_val;
            dec_imm = imm_b; dec_aluop = {3'b100, f3}; take = br_cond; target = pc_i + imm_b;
         end
         OPC_LOAD: begin
            dec_illegal = (f3 == 3'd3) || (f3 > 3'd5);
            uses_rs1 = 1'b1; dec_op1 = rs1_val; dec_op2 = imm_i; dec_imm = imm_i;
            dec_aluop = {3'b010, f3}; dec_wreg = 1'b1;
         end
         OPC_STORE: begin
            dec_illegal = (f3 > 3'd2);
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_op1 = rs1_val; dec_op2 = rs2_val;
            dec_imm = imm_s; dec_aluop = {3'b011, f3};
         end
         OPC_OPIMM: begin
            uses_rs1 = 1'b1; dec_op1 = rs1_val; dec_op2 = imm_i; dec_imm = imm_i; dec_wreg = 1'b1;
            dec_aluop = alu_of(f3, 1'b0);
            if (f3 == 3'd1 || f3 == 3'd5) begin
               dec_op2 = shamt;
               dec_aluop = alu_of(f3, f7[5]);
               dec_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
            end
         end
         OPC_OP: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_op1 = rs1_val; dec_op2 = rs2_val;
            dec_wreg = 1'b1; dec_aluop = alu_of(f3, f7[5]);
            dec_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal words travel down the pipe as an inert marker.
      if (dec_illegal) begin
         dec_aluop = '0; dec_op1 = '0; dec_op2 = '0; dec_imm = '0; dec_link = '0;
         dec_wreg = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0; take = 1'b0;
      end
      if (rd == 5'd0) dec_wreg = 1'b0;
   end

   state_t     state_reg, state_next;
   logic [1:0] cnt_reg, cnt_next;
   logic       hazard, accept_run, take_now;

   assign hazard = ex_is_load_i && ex_rd_i != 5'd0 && if_valid_i &&
                   ((uses_rs1 && rs1 == ex_rd_i) || (uses_rs2 && rs2 == ex_rd_i));
   assign id_ready_o = ex_ready_i && (state_reg == KILL || !hazard);
   assign accept_run = if_valid_i && ex_ready_i && !hazard && state_reg == RUN;
   assign take_now   = accept_run && take;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         RUN: if (take_now) begin
            state_next = KILL;
            cnt_next   = 2'(SHADOW);
         end
         default: if (if_valid_i && ex_ready_i) begin
            if (cnt_reg <= 2'd1) begin
               state_next = RUN;
               cnt_next   = 2'd0;
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RUN;       cnt_reg <= '0;
         ex_valid_o <= 1'b0;     ex_aluop_o <= '0;  ex_op1_o <= '0;  ex_op2_o <= '0;
         ex_imm_o <= '0;         ex_rd_o <= '0;     ex_wreg_o <= 1'b0;
         ex_link_o <= '0;        ex_illegal_o <= 1'b0;
         jump_o <= 1'b0;         jump_addr_o <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         jump_o      <= take_now;
         jump_addr_o <= take_now ? target : '0;
         if (ex_ready_i) begin
            ex_valid_o   <= accept_run;
            ex_aluop_o   <= accept_run ? dec_aluop : '0;
            ex_op1_o     <= accept_run ? dec_op1 : '0;
            ex_op2_o     <= accept_run ? dec_op2 : '0;
            ex_imm_o     <= accept_run ? dec_imm : '0;
            ex_rd_o      <= accept_run ? rd : '0;
            ex_wreg_o    <= accept_run && dec_wreg;
            ex_link_o    <= accept_run ? dec_link : '0;
            ex_illegal_o <= accept_run && dec_illegal;
         end
      end
   end
endmodule
